lp_alu_pipe: RTL and testbench

- Parametrised, pipelined low-power ALU; next generation of the team's 8-bit gated ALU.
- Adds:
  - generic data width
  - valid/ready handshake with backpressure
  - full flag set (zero/carry/negative/overflow), taken from the same result they describe
  - barrel shifts
  - self-timed idle power-down FSM that drives the datapath clock-gate enable.
- Sits between an operand source and a result sink in the datapath cluster.

---
 rtl/lp_alu_pipe.sv | 183 ++++++++++++++++++
 tb/tb_lp_alu_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lp_alu_pipe.sv
// Two-stage pipelined ALU with valid/ready backpressure, full flags and an idle power-down FSM.
// Optional unsigned saturation of add/sub is enabled by defining LP_ALU_PIPE_SAT_EN.
module lp_alu_pipe #(
    parameter int WIDTH       = 8,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             sleep
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2
    } pwr_state_e;

    pwr_state_e       state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic             valid_a_q;
    logic [2:0]       op_a_q;
    logic [WIDTH-1:0] a_a_q, b_a_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q, y_d;
    logic [3:0]       flags_q, flags_d;

    logic adv, accept, idle, gate_en, load_b;

    // Handshake: a beat moves on in_valid && in_ready, a result leaves on
    // out_valid && out_ready; every stage holds while the output is stalled.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;
    assign idle     = !accept && !valid_a_q && !out_valid_q;
    assign load_b   = adv && valid_a_q;

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;
    assign sleep     = (state_q == ST_SLEEP);

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        gate_en    = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (idle) begin
                    if (idle_cnt_q == CNT_W'(IDLE_CYCLES)) begin
                        state_d    = ST_SLEEP;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            ST_SLEEP: begin
                gate_en = 1'b0;
                if (in_valid) state_d = ST_WAKE;
            end
            ST_WAKE: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
            end
            default: begin
                state_d    = ST_RUN;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            idle_cnt_q  <= '0;
            valid_a_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            if (adv) begin
                valid_a_q   <= accept;
                out_valid_q <= valid_a_q;
            end
        end
    end

    // Datapath registers: gate_en stands in for the clock-gate enable, and the
    // operands only load on accept so the compute cone stays quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            a_a_q   <= '0;
            b_a_q   <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else if (gate_en) begin
            if (accept) begin
                op_a_q <= op;
                a_a_q  <= a;
                b_a_q  <= b;
            end
            if (load_b) begin
                y_q     <= y_d;
                flags_q <= flags_d;
            end
        end
    end

    logic [SHW-1:0] amt;
    logic [WIDTH:0] sum, diff, shl, shr;
    logic           res_c, res_v;

    always_comb begin
        amt   = b_a_q[SHW-1:0];
        sum   = {1'b0, a_a_q} + {1'b0, b_a_q};
        diff  = {1'b0, a_a_q} - {1'b0, b_a_q};
        // One extra bit on the exit side catches the last bit shifted out.
        shl   = {1'b0, a_a_q} << amt;
        shr   = {a_a_q, 1'b0} >> amt;
        y_d   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_a_q)
            OP_ADD: begin
                y_d   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a_a_q[WIDTH-1] == b_a_q[WIDTH-1]) && (sum[WIDTH-1] != a_a_q[WIDTH-1]);
`ifdef LP_ALU_PIPE_SAT_EN
                if (sum[WIDTH]) y_d = '1;
`endif
            end
            OP_SUB: begin
                y_d   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a_a_q[WIDTH-1] != b_a_q[WIDTH-1]) && (diff[WIDTH-1] != a_a_q[WIDTH-1]);
`ifdef LP_ALU_PIPE_SAT_EN
                if (diff[WIDTH]) y_d = '0;
`endif
            end
            OP_AND: y_d = a_a_q & b_a_q;
            OP_OR:  y_d = a_a_q | b_a_q;
            OP_XOR: y_d = a_a_q ^ b_a_q;
            OP_NOT: y_d = ~a_a_q;
            OP_SHL: begin
                y_d   = shl[WIDTH-1:0];
                res_c = shl[WIDTH];
            end
            OP_SHR: begin
                y_d   = shr[WIDTH:1];
                res_c = shr[0];
            end
            default: y_d = '0;
        endcase
        flags_d = {res_v, y_d[WIDTH-1], res_c, (y_d == '0)};
    end

endmodule

// File: tb/tb_lp_alu_pipe.sv
// Directed self-checking bench for lp_alu_pipe (WIDTH=8, IDLE_CYCLES=4).
module tb_lp_alu_pipe;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // flags = {ovf, neg, carry, zero}
`ifdef LP_ALU_PIPE_SAT_EN
    localparam logic [7:0] ADD_FF_Y  = 8'hFF;
    localparam logic [3:0] ADD_FF_F  = 4'b0110;
    localparam logic [7:0] SUB_12_Y  = 8'h00;
    localparam logic [3:0] SUB_12_F  = 4'b0011;
    localparam logic [11:0] BP3_EXP  = 12'h6FF;
`else
    localparam logic [7:0] ADD_FF_Y  = 8'h00;
    localparam logic [3:0] ADD_FF_F  = 4'b0011;
    localparam logic [7:0] SUB_12_Y  = 8'hFF;
    localparam logic [3:0] SUB_12_F  = 4'b0110;
    localparam logic [11:0] BP3_EXP  = 12'h210;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic [3:0] flags;
    logic       sleep;

    int err_cnt = 0;
    int chk_cnt = 0;

    lp_alu_pipe #(.WIDTH(8), .IDLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .sleep     (sleep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Single beat into an empty pipeline; starts and ends on a falling edge.
    task automatic run_one(input string tag, input logic [2:0] op_v, input logic [7:0] a_v,
                           input logic [7:0] b_v, input logic [7:0] ey, input logic [3:0] ef);
        in_valid = 1'b1;
        op = op_v;
        a = a_v;
        b = b_v;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_y"}, y, ey);
        check({tag, "_flags"}, flags, ef);
        @(negedge clk);
    endtask

    logic [7:0]  bp_a[4]   = '{8'h10, 8'h20, 8'h7F, 8'hF0};
    logic [7:0]  bp_b[4]   = '{8'h01, 8'h02, 8'h01, 8'h20};
    logic [11:0] bp_exp[4] = '{12'h011, 12'h022, 12'hC80, BP3_EXP};
    logic [11:0] exp_q[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, stall;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_flags", flags, 0);
        check("rst_sleep", sleep, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main function, including carry/borrow/overflow and shift edges
        run_one("add_ff_01", OP_ADD, 8'hFF, 8'h01, ADD_FF_Y, ADD_FF_F);
        run_one("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000);
        run_one("sub_01_02", OP_SUB, 8'h01, 8'h02, SUB_12_Y, SUB_12_F);
        run_one("shl_81_1",  OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010);
        run_one("shr_81_3",  OP_SHR, 8'h81, 8'h03, 8'h10, 4'b0000);
        run_one("shr_amt0",  OP_SHR, 8'h81, 8'h00, 8'h81, 4'b0100);
        run_one("shl_amt0",  OP_SHL, 8'h5A, 8'h08, 8'h5A, 4'b0000);
        run_one("and",       OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        run_one("or",        OP_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100);
        run_one("xor_zero",  OP_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001);
        run_one("not",       OP_NOT, 8'h0F, 8'h55, 8'hF0, 4'b0100);
        run_one("add_ovf",   OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100);

        // Backpressure: four adds while the sink stalls at first
        sent = 0;
        got = 0;
        stall = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            if (sent < 4) begin
                in_valid = 1'b1;
                op = OP_ADD;
                a = bp_a[sent];
                b = bp_b[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && !in_ready) stall++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected_beat", out_valid, 0);
                end else if (out_ready) begin
                    check("bp_result", {flags, y}, exp_q.pop_front());
                    got++;
                end else begin
                    check("bp_hold", {flags, y}, exp_q[0]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bp_exp[sent]);
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", sent, 4);
        check("bp_got", got, 4);
        check("bp_stalled", stall > 0, 1);
        #1;
        check("bp_drained", out_valid, 0);
        @(negedge clk);

        // Idle power-down and wake from a clean reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("idle4_sleep", sleep, 0);
        @(negedge clk);
        #1;
        check("idle5_sleep", sleep, 1);
        check("sleep_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_AND;
        a = 8'hF0;
        b = 8'h3C;
        #1;
        check("sleep_hold_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("wake_sleep", sleep, 0);
        check("wake_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("run_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("wake_lat1", out_valid, 0);
        @(negedge clk);
        #1;
        check("wake_out_valid", out_valid, 1);
        check("wake_y", y, 8'h30);
        check("wake_flags", flags, 4'b0000);
        @(negedge clk);

        // Async reset with a result pending
        in_valid = 1'b1;
        op = OP_ADD;
        a = 8'h7F;
        b = 8'h01;
        @(negedge clk);
        op = OP_OR;
        a = 8'h0F;
        b = 8'h30;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_y", y, 8'h80);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_y", y, 0);
        check("arst_flags", flags, 0);
        check("arst_sleep", sleep, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one("post_rst_add", OP_ADD, 8'h03, 8'h04, 8'h07, 4'b0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
